// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multi-cycle control unit.
// Holds the FSM state encoding, the opcode map, the ALU operation codes
// (shared with the ALU), the ALU operand source codes and the PC source
// codes, plus small opcode classification helpers.
// The TRAP state exists only when OVERFLOW_TRAP_EN is defined.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    EXEC_R     = 4'd2,
    EXEC_I     = 4'd3,
    MEM_ADDR   = 4'd4,
    MEM_RD     = 4'd5,
    MEM_WR     = 4'd6,
    WB_ALU     = 4'd7,
    WB_MEM     = 4'd8,
    BRANCH     = 4'd9,
    BR_RESOLVE = 4'd10,
    JUMP       = 4'd11
`ifdef OVERFLOW_TRAP_EN
    ,
    TRAP       = 4'd12
`endif
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_ANDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BLT  = 6'd8;
  localparam logic [5:0] OP_J    = 6'd9;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // ALU operand sources
  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_BOFF = 2'b10;

  // PC sources
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // Ops whose signed result can overflow into the register file
  function automatic logic traps_on_overflow(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_out_decode.sv
// control_out_decode: combinational state/opcode to datapath-control decoder.
// Ports: reset (forces all strobes idle), state, opcode, mem_ready (FETCH
// Mealy strobes), ALU flags (branch resolve, overflow writeback suppression);
// outputs are the ALU op/source selects, write/access strobes, register
// destination, writeback mux, PC source and the trap pulse.
// OVERFLOW_TRAP_EN enables the TRAP state outputs and writeback suppression;
// otherwise sig_trap stays 0.
module control_out_decode
  import control_pkg::*;
#(
  parameter logic [1:0] TRAP_VECTOR_SEL = 2'b11
) (
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       flag_zero,
  input  logic       flag_negative,
  input  logic       flag_overflow,
  output logic [1:0] sig_alu_op,
  output logic       sig_alu_src_a,
  output logic [1:0] sig_alu_src_b,
  output logic       sig_pc_write,
  output logic       sig_ir_write,
  output logic       sig_mem_read,
  output logic       sig_mem_write,
  output logic       sig_reg_write,
  output logic       sig_reg_dst,
  output logic       sig_mem_to_reg,
  output logic [1:0] sig_pc_src,
  output logic       sig_trap
);

`ifndef OVERFLOW_TRAP_EN
  logic unused_trap_vec_s;
  assign unused_trap_vec_s = ^TRAP_VECTOR_SEL;
`endif

  // Output decode: idle defaults, then per-state overrides unless in reset
  always_comb begin
    sig_alu_op     = ALU_ADD;
    sig_alu_src_a  = SRC_A_PC;
    sig_alu_src_b  = SRC_B_REG;
    sig_pc_write   = 1'b0;
    sig_ir_write   = 1'b0;
    sig_mem_read   = 1'b0;
    sig_mem_write  = 1'b0;
    sig_reg_write  = 1'b0;
    sig_reg_dst    = 1'b0;
    sig_mem_to_reg = 1'b0;
    sig_pc_src     = PC_SRC_SEQ;
    sig_trap       = 1'b0;
    if (reset) begin
      sig_pc_write = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          sig_mem_read = 1'b1;
          // IR load and PC+4 happen in the cycle the memory completes
          if (mem_ready) begin
            sig_ir_write = 1'b1;
            sig_pc_write = 1'b1;
          end else begin
            sig_ir_write = 1'b0;
            sig_pc_write = 1'b0;
          end
        end
        DECODE: begin
          // Speculative branch target: PC + shifted offset
          sig_alu_src_a = SRC_A_PC;
          sig_alu_src_b = SRC_B_BOFF;
        end
        EXEC_R: begin
          sig_alu_src_a = SRC_A_REG;
          sig_alu_src_b = SRC_B_REG;
          case (opcode)
            OP_SUB:  sig_alu_op = ALU_SUB;
            OP_AND:  sig_alu_op = ALU_AND;
            default: sig_alu_op = ALU_ADD;
          endcase
        end
        EXEC_I: begin
          sig_alu_src_a = SRC_A_REG;
          sig_alu_src_b = SRC_B_IMM;
          if (opcode == OP_ANDI) begin
            sig_alu_op = ALU_AND;
          end else begin
            sig_alu_op = ALU_ADD;
          end
        end
        MEM_ADDR: begin
          sig_alu_src_a = SRC_A_REG;
          sig_alu_src_b = SRC_B_IMM;
        end
        MEM_RD:  sig_mem_read  = 1'b1;
        MEM_WR:  sig_mem_write = 1'b1;
        WB_ALU: begin
          sig_reg_dst = is_rtype(opcode);
`ifdef OVERFLOW_TRAP_EN
          sig_reg_write = !(flag_overflow && traps_on_overflow(opcode));
`else
          sig_reg_write = 1'b1;
`endif
        end
        WB_MEM: begin
          sig_reg_write  = 1'b1;
          sig_mem_to_reg = 1'b1;
          sig_reg_dst    = 1'b0;
        end
        BRANCH: begin
          sig_alu_op    = ALU_SUB;
          sig_alu_src_a = SRC_A_REG;
          sig_alu_src_b = SRC_B_REG;
        end
        BR_RESOLVE: begin
          // BLT uses N^V so the signed compare survives subtraction overflow
          if (((opcode == OP_BEQ) && flag_zero) ||
              ((opcode == OP_BLT) && (flag_negative ^ flag_overflow))) begin
            sig_pc_write = 1'b1;
            sig_pc_src   = PC_SRC_BRANCH;
          end else begin
            sig_pc_write = 1'b0;
          end
        end
        JUMP: begin
          sig_pc_write = 1'b1;
          sig_pc_src   = PC_SRC_JUMP;
        end
`ifdef OVERFLOW_TRAP_EN
        TRAP: begin
          sig_trap     = 1'b1;
          sig_pc_write = 1'b1;
          sig_pc_src   = TRAP_VECTOR_SEL;
        end
`endif
        default: sig_pc_write = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for the processor datapath.
// Ports: clock, reset (synchronous, active-high), opcode (IR[31:26]),
// mem_ready (memory handshake), ALU flags; outputs the ALU op/source
// selects, all datapath write strobes and mux selects, sig_trap and the
// current state for debug.
// OVERFLOW_TRAP_EN: when defined, an overflowing ADD/SUB/ADDI skips its
// register write and takes a one-cycle TRAP to TRAP_VECTOR_SEL.
module control_unit
  import control_pkg::*;
#(
  parameter logic [1:0] TRAP_VECTOR_SEL = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       flag_zero,
  input  logic       flag_negative,
  input  logic       flag_overflow,
  output logic [1:0] sig_alu_op,
  output logic       sig_alu_src_a,
  output logic [1:0] sig_alu_src_b,
  output logic       sig_pc_write,
  output logic       sig_ir_write,
  output logic       sig_mem_read,
  output logic       sig_mem_write,
  output logic       sig_reg_write,
  output logic       sig_reg_dst,
  output logic       sig_mem_to_reg,
  output logic [1:0] sig_pc_src,
  output logic       sig_trap,
  output logic [3:0] state
);

  state_t state_r;

  // State register and next-state sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH:    state_r <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND: state_r <= EXEC_R;
            OP_ADDI, OP_ANDI:       state_r <= EXEC_I;
            OP_LW, OP_SW:           state_r <= MEM_ADDR;
            OP_BEQ, OP_BLT:         state_r <= BRANCH;
            OP_J:                   state_r <= JUMP;
            default:                state_r <= FETCH;
          endcase
        end
        EXEC_R:     state_r <= WB_ALU;
        EXEC_I:     state_r <= WB_ALU;
        MEM_ADDR:   state_r <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:     state_r <= mem_ready ? WB_MEM : MEM_RD;
        MEM_WR:     state_r <= mem_ready ? FETCH : MEM_WR;
`ifdef OVERFLOW_TRAP_EN
        WB_ALU:     state_r <= (flag_overflow && traps_on_overflow(opcode)) ? TRAP : FETCH;
        TRAP:       state_r <= FETCH;
`else
        WB_ALU:     state_r <= FETCH;
`endif
        WB_MEM:     state_r <= FETCH;
        BRANCH:     state_r <= BR_RESOLVE;
        BR_RESOLVE: state_r <= FETCH;
        JUMP:       state_r <= FETCH;
        default:    state_r <= FETCH;
      endcase
    end
  end

  assign state = state_r;

  control_out_decode #(
    .TRAP_VECTOR_SEL(TRAP_VECTOR_SEL)
  ) u_out_decode (
    .reset          (reset),
    .state          (state_r),
    .opcode         (opcode),
    .mem_ready      (mem_ready),
    .flag_zero      (flag_zero),
    .flag_negative  (flag_negative),
    .flag_overflow  (flag_overflow),
    .sig_alu_op     (sig_alu_op),
    .sig_alu_src_a  (sig_alu_src_a),
    .sig_alu_src_b  (sig_alu_src_b),
    .sig_pc_write   (sig_pc_write),
    .sig_ir_write   (sig_ir_write),
    .sig_mem_read   (sig_mem_read),
    .sig_mem_write  (sig_mem_write),
    .sig_reg_write  (sig_reg_write),
    .sig_reg_dst    (sig_reg_dst),
    .sig_mem_to_reg (sig_mem_to_reg),
    .sig_pc_src     (sig_pc_src),
    .sig_trap       (sig_trap)
  );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Output bundle layout (15 bits):
//   alu_op(2) _ src_a(1) _ src_b(2) _ {pc_w,ir_w,mem_rd,mem_wr,reg_w}(5)
//   _ {reg_dst,mem_to_reg}(2) _ pc_src(2) _ trap(1)
module tb_control_unit;
  import control_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       flag_zero, flag_negative, flag_overflow;
  logic [1:0] sig_alu_op, sig_alu_src_b, sig_pc_src;
  logic       sig_alu_src_a, sig_pc_write, sig_ir_write, sig_mem_read;
  logic       sig_mem_write, sig_reg_write, sig_reg_dst, sig_mem_to_reg, sig_trap;
  logic [3:0] state;
  logic [14:0] outs_s;

  int checks = 0;
  int failures = 0;

  // Hand-derived expected bundles
  localparam logic [14:0] O_IDLE   = 15'b00_0_00_00000_00_00_0;
  localparam logic [14:0] O_FET_RD = 15'b00_0_00_11100_00_00_0;
  localparam logic [14:0] O_FET_WT = 15'b00_0_00_00100_00_00_0;
  localparam logic [14:0] O_DEC    = 15'b00_0_10_00000_00_00_0;
  localparam logic [14:0] O_EX_ADD = 15'b00_1_00_00000_00_00_0;
  localparam logic [14:0] O_EX_SUB = 15'b01_1_00_00000_00_00_0;
  localparam logic [14:0] O_EX_ANI = 15'b10_1_01_00000_00_00_0;
  localparam logic [14:0] O_WB_R   = 15'b00_0_00_00001_10_00_0;
  localparam logic [14:0] O_WB_I   = 15'b00_0_00_00001_00_00_0;
  localparam logic [14:0] O_MADDR  = 15'b00_1_01_00000_00_00_0;
  localparam logic [14:0] O_MRD    = 15'b00_0_00_00100_00_00_0;
  localparam logic [14:0] O_WB_MEM = 15'b00_0_00_00001_01_00_0;
  localparam logic [14:0] O_MWR    = 15'b00_0_00_00010_00_00_0;
  localparam logic [14:0] O_BR     = 15'b01_1_00_00000_00_00_0;
  localparam logic [14:0] O_BR_TK  = 15'b00_0_00_10000_00_01_0;
  localparam logic [14:0] O_JMP    = 15'b00_0_00_10000_00_10_0;
  localparam logic [14:0] O_WB_OVF = 15'b00_0_00_00000_10_00_0;
  localparam logic [14:0] O_TRAP   = 15'b00_0_00_10000_00_11_1;

  assign outs_s = {sig_alu_op, sig_alu_src_a, sig_alu_src_b, sig_pc_write, sig_ir_write,
                   sig_mem_read, sig_mem_write, sig_reg_write, sig_reg_dst, sig_mem_to_reg,
                   sig_pc_src, sig_trap};

  control_unit dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .flag_zero(flag_zero), .flag_negative(flag_negative), .flag_overflow(flag_overflow),
    .sig_alu_op(sig_alu_op), .sig_alu_src_a(sig_alu_src_a), .sig_alu_src_b(sig_alu_src_b),
    .sig_pc_write(sig_pc_write), .sig_ir_write(sig_ir_write), .sig_mem_read(sig_mem_read),
    .sig_mem_write(sig_mem_write), .sig_reg_write(sig_reg_write), .sig_reg_dst(sig_reg_dst),
    .sig_mem_to_reg(sig_mem_to_reg), .sig_pc_src(sig_pc_src), .sig_trap(sig_trap),
    .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL reset_state: got %0d want %0d", state, FETCH); end
    checks++;
    if (outs_s !== O_IDLE) begin failures++; $display("FAIL reset_outs: got %b want %b", outs_s, O_IDLE); end
    // Walk an LW into MEM_RD, then reset it mid-access
    reset = 1'b0; opcode = OP_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== MEM_RD) begin failures++; $display("FAIL reset_reach_memrd: got %0d want %0d", state, MEM_RD); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs_s !== O_IDLE) begin failures++; $display("FAIL reset_hold_outs cyc %0d: got %b want %b", i, outs_s, O_IDLE); end
      tick();
      checks++;
      if (state !== FETCH) begin failures++; $display("FAIL reset_hold_state cyc %0d: got %0d want %0d", i, state, FETCH); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs_s !== O_FET_WT) begin failures++; $display("FAIL reset_release_memrd: got %b want %b", outs_s, O_FET_WT); end
  endtask

  task automatic test_add();
    logic [3:0]  est[4]  = '{FETCH, DECODE, EXEC_R, WB_ALU};
    logic [14:0] eout[4] = '{O_FET_RD, O_DEC, O_EX_ADD, O_WB_R};
    opcode = OP_ADD; mem_ready = 1'b1;
    flag_zero = 1'b0; flag_negative = 1'b0; flag_overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL add_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL add_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL add_done: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_andi();
    logic [3:0]  est[4]  = '{FETCH, DECODE, EXEC_I, WB_ALU};
    logic [14:0] eout[4] = '{O_FET_RD, O_DEC, O_EX_ANI, O_WB_I};
    opcode = OP_ANDI; mem_ready = 1'b1; flag_overflow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL andi_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL andi_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    flag_overflow = 1'b0;
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL andi_done: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  est[7]  = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, WB_MEM};
    logic [14:0] eout[7] = '{O_FET_RD, O_DEC, O_MADDR, O_MRD, O_MRD, O_MRD, O_WB_MEM};
    logic        mr[7]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL lw_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL lw_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL lw_done: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  est[5]  = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR};
    logic [14:0] eout[5] = '{O_FET_RD, O_DEC, O_MADDR, O_MWR, O_MWR};
    logic        mr[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL sw_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL sw_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL sw_done: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic n,
                             input logic v, input logic taken);
    logic [3:0]  est[4]  = '{FETCH, DECODE, BRANCH, BR_RESOLVE};
    logic [14:0] eout[4] = '{O_FET_RD, O_DEC, O_BR, O_IDLE};
    eout[3] = taken ? O_BR_TK : O_IDLE;
    opcode = op; mem_ready = 1'b1;
    flag_zero = z; flag_negative = n; flag_overflow = v;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL branch_state op %0d cyc %0d: got %0d want %0d", op, i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL branch_outs op %0d cyc %0d: got %b want %b", op, i, outs_s, eout[i]); end
      tick();
    end
    flag_zero = 1'b0; flag_negative = 1'b0; flag_overflow = 1'b0;
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL branch_done op %0d: got %0d want %0d", op, state, FETCH); end
  endtask

  task automatic test_jump();
    logic [3:0]  est[3]  = '{FETCH, DECODE, JUMP};
    logic [14:0] eout[3] = '{O_FET_RD, O_DEC, O_JMP};
    opcode = OP_J; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL jump_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL jump_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL jump_done: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_illegal(input logic [5:0] op);
    logic [3:0]  est[2]  = '{FETCH, DECODE};
    logic [14:0] eout[2] = '{O_FET_RD, O_DEC};
    opcode = op; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL illegal_state op %0d cyc %0d: got %0d want %0d", op, i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL illegal_outs op %0d cyc %0d: got %b want %b", op, i, outs_s, eout[i]); end
      tick();
    end
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL illegal_done op %0d: got %0d want %0d", op, state, FETCH); end
  endtask

  task automatic test_overflow();
`ifdef OVERFLOW_TRAP_EN
    logic [3:0]  est[5]  = '{FETCH, DECODE, EXEC_R, WB_ALU, TRAP};
    logic [14:0] eout[5] = '{O_FET_RD, O_DEC, O_EX_SUB, O_WB_OVF, O_TRAP};
    localparam int N = 5;
`else
    logic [3:0]  est[4]  = '{FETCH, DECODE, EXEC_R, WB_ALU};
    logic [14:0] eout[4] = '{O_FET_RD, O_DEC, O_EX_SUB, O_WB_R};
    localparam int N = 4;
`endif
    opcode = OP_SUB; mem_ready = 1'b1; flag_overflow = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      checks++;
      if (state !== est[i]) begin failures++; $display("FAIL ovf_state cyc %0d: got %0d want %0d", i, state, est[i]); end
      checks++;
      if (outs_s !== eout[i]) begin failures++; $display("FAIL ovf_outs cyc %0d: got %b want %b", i, outs_s, eout[i]); end
      tick();
    end
    flag_overflow = 1'b0;
    checks++;
    if (state !== FETCH) begin failures++; $display("FAIL ovf_done: got %0d want %0d", state, FETCH); end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    flag_zero = 1'b0; flag_negative = 1'b0; flag_overflow = 1'b0;
    tick(); tick();
    test_reset();
    test_add();
    test_andi();
    test_lw_wait();
    test_sw_wait();
    test_branch(OP_BEQ, 1'b1, 1'b0, 1'b0, 1'b1);
    test_branch(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    test_branch(OP_BLT, 1'b0, 1'b1, 1'b0, 1'b1);
    test_branch(OP_BLT, 1'b0, 1'b1, 1'b1, 1'b0);
    test_branch(OP_BLT, 1'b1, 1'b0, 1'b1, 1'b1);
    test_jump();
    test_illegal(6'h3F);
    test_illegal(6'h0A);
    test_overflow();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
